// File: rtl/complete_arbiter_pkg.sv
// Shared types and constants for the completion arbiter: completion entry layout,
// default sizing and tag widths.
package complete_arbiter_pkg;

  localparam int unsigned DEFAULT_DEPTH   = 8;
  localparam int unsigned DEFAULT_NUM_OUT = 2;
  localparam int unsigned NUM_LANES       = 3;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned TAG_W           = 6;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] dest_reg;
    logic [TAG_W-1:0] rob_num;
  } cmp_entry_t;

endpackage

// File: rtl/complete_arbiter_cmp_fifo.sv
// Circular completion FIFO: up to 3 writes and 2 reads per edge, combinational
// peek of the two oldest entries.
module cmp_fifo
  import complete_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned NUM_OUT = DEFAULT_NUM_OUT
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                flush,
  input  logic [1:0]                          wr_cnt,
  input  cmp_entry_t [NUM_LANES-1:0]          wr_data,
  input  logic [1:0]                          rd_cnt,
  output cmp_entry_t [NUM_OUT-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmp_entry_t       mem_q [DEPTH];
  cmp_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_cnt);
    count_d  = count_q + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);
    // Power-of-two DEPTH lets pointer overflow do the wrap.
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (i < 32'(wr_cnt)) mem_d[wr_ptr_q + PTR_W'(i)] = wr_data[i];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      rd_data[k] = mem_q[rd_ptr_q + PTR_W'(k)];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;

endmodule

// File: rtl/complete_arbiter.sv
// Three-lane to two-port completion arbiter: compacts valid lanes into a FIFO and
// broadcasts the two oldest per cycle. Optional COMPLETE_ARBITER_BYPASS_EN skips the FIFO when empty.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned NUM_OUT = DEFAULT_NUM_OUT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_issue0_in,
  input  logic [XLEN-1:0]  PC_issue0_in,
  input  logic [XLEN-1:0]  aluOutput_issue0_in,
  input  logic [TAG_W-1:0] destReg_issue0_in,
  input  logic [TAG_W-1:0] ROBNum_issue0_in,
  input  logic             valid_issue1_in,
  input  logic [XLEN-1:0]  PC_issue1_in,
  input  logic [XLEN-1:0]  aluOutput_issue1_in,
  input  logic [TAG_W-1:0] destReg_issue1_in,
  input  logic [TAG_W-1:0] ROBNum_issue1_in,
  input  logic             valid_issue2_in,
  input  logic [XLEN-1:0]  PC_issue2_in,
  input  logic [XLEN-1:0]  aluOutput_issue2_in,
  input  logic [TAG_W-1:0] destReg_issue2_in,
  input  logic [TAG_W-1:0] ROBNum_issue2_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             cmp0_valid_out,
  output logic [XLEN-1:0]  cmp0_PC_out,
  output logic [XLEN-1:0]  cmp0_result_out,
  output logic [TAG_W-1:0] cmp0_destReg_out,
  output logic [TAG_W-1:0] cmp0_ROBNum_out,
  output logic             cmp1_valid_out,
  output logic [XLEN-1:0]  cmp1_PC_out,
  output logic [XLEN-1:0]  cmp1_result_out,
  output logic [TAG_W-1:0] cmp1_destReg_out,
  output logic [TAG_W-1:0] cmp1_ROBNum_out
);

`ifdef COMPLETE_ARBITER_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  cmp_entry_t [NUM_LANES-1:0] lane;
  logic       [NUM_LANES-1:0] lane_v;
  cmp_entry_t [NUM_LANES-1:0] pack;
  logic [1:0]                 n_valid, n_acc, byp, deq, wr_cnt;
  cmp_entry_t [NUM_LANES-1:0] wr_data;
  cmp_entry_t [NUM_OUT-1:0]   rd_data;
  logic [$clog2(DEPTH):0]     count;

  logic       [NUM_OUT-1:0]   cmp_valid_q, cmp_valid_d;
  cmp_entry_t [NUM_OUT-1:0]   cmp_data_q, cmp_data_d;

  assign lane[0] = '{pc: PC_issue0_in, result: aluOutput_issue0_in,
                     dest_reg: destReg_issue0_in, rob_num: ROBNum_issue0_in};
  assign lane[1] = '{pc: PC_issue1_in, result: aluOutput_issue1_in,
                     dest_reg: destReg_issue1_in, rob_num: ROBNum_issue1_in};
  assign lane[2] = '{pc: PC_issue2_in, result: aluOutput_issue2_in,
                     dest_reg: destReg_issue2_in, rob_num: ROBNum_issue2_in};
  assign lane_v  = {valid_issue2_in, valid_issue1_in, valid_issue0_in};

  assign stall_out = (32'(count) > DEPTH - 3);

  // Compaction: lowest valid lane lands in slot 0 (oldest).
  always_comb begin
    pack    = '0;
    n_valid = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (lane_v[i]) begin
        pack[n_valid] = lane[i];
        n_valid       = n_valid + 2'd1;
      end
    end
  end

  always_comb begin
    n_acc = (!stall_out && !flush_in) ? n_valid : 2'd0;
    byp   = '0;
    deq   = '0;
    if (!flush_in) begin
      if (BYPASS_EN && count == '0) byp = (32'(n_acc) > NUM_OUT) ? 2'(NUM_OUT) : n_acc;
      else                          deq = (32'(count) > NUM_OUT) ? 2'(NUM_OUT) : 2'(count);
    end
    wr_cnt = n_acc - byp;
    for (int unsigned j = 0; j < NUM_LANES; j++) begin
      wr_data[j] = (j + 32'(byp) < NUM_LANES) ? pack[2'(j + 32'(byp))] : '0;
    end

    cmp_valid_d = '0;
    cmp_data_d  = cmp_data_q;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (k < 32'(byp)) begin
        cmp_valid_d[k] = 1'b1;
        cmp_data_d[k]  = pack[k];
      end else if (k < 32'(deq)) begin
        cmp_valid_d[k] = 1'b1;
        cmp_data_d[k]  = rd_data[k];
      end
    end
  end

  cmp_fifo #(.DEPTH(DEPTH), .NUM_OUT(NUM_OUT)) u_cmp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush_in),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_cnt  (deq),
    .rd_data (rd_data),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_valid_q <= '0;
      cmp_data_q  <= '0;
    end else begin
      cmp_valid_q <= cmp_valid_d;
      cmp_data_q  <= cmp_data_d;
    end
  end

  assign cmp0_valid_out   = cmp_valid_q[0];
  assign cmp0_PC_out      = cmp_data_q[0].pc;
  assign cmp0_result_out  = cmp_data_q[0].result;
  assign cmp0_destReg_out = cmp_data_q[0].dest_reg;
  assign cmp0_ROBNum_out  = cmp_data_q[0].rob_num;
  assign cmp1_valid_out   = cmp_valid_q[1];
  assign cmp1_PC_out      = cmp_data_q[1].pc;
  assign cmp1_result_out  = cmp_data_q[1].result;
  assign cmp1_destReg_out = cmp_data_q[1].dest_reg;
  assign cmp1_ROBNum_out  = cmp_data_q[1].rob_num;

endmodule

// File: tb/tb_complete_arbiter.sv
// Self-checking bench for complete_arbiter: fixed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_complete_arbiter;

  localparam int unsigned DEPTH = 8;
`ifdef COMPLETE_ARBITER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  lane_v = '0;
  logic [5:0]  lane_rob [3];
  logic [75:0] lane_e [3];
  logic        flush_in = 1'b0;
  logic        stall_out;
  logic        cmp0_valid_out, cmp1_valid_out;
  logic [31:0] cmp0_PC_out, cmp0_result_out, cmp1_PC_out, cmp1_result_out;
  logic [5:0]  cmp0_destReg_out, cmp0_ROBNum_out, cmp1_destReg_out, cmp1_ROBNum_out;

  always #5 clk = ~clk;

  function automatic logic [75:0] ent(input logic [5:0] r);
    logic [31:0] pc, res;
    pc  = 32'h1000 + {24'h0, r, 2'b00};
    res = {26'h0, r} * 32'd3 + 32'd7;
    return {pc, res, r ^ 6'h15, r};
  endfunction

  always_comb for (int i = 0; i < 3; i++) lane_e[i] = ent(lane_rob[i]);

  complete_arbiter #(.DEPTH(DEPTH), .NUM_OUT(2)) dut (
    .clk(clk), .rstn(rstn),
    .valid_issue0_in(lane_v[0]), .PC_issue0_in(lane_e[0][75:44]), .aluOutput_issue0_in(lane_e[0][43:12]),
    .destReg_issue0_in(lane_e[0][11:6]), .ROBNum_issue0_in(lane_e[0][5:0]),
    .valid_issue1_in(lane_v[1]), .PC_issue1_in(lane_e[1][75:44]), .aluOutput_issue1_in(lane_e[1][43:12]),
    .destReg_issue1_in(lane_e[1][11:6]), .ROBNum_issue1_in(lane_e[1][5:0]),
    .valid_issue2_in(lane_v[2]), .PC_issue2_in(lane_e[2][75:44]), .aluOutput_issue2_in(lane_e[2][43:12]),
    .destReg_issue2_in(lane_e[2][11:6]), .ROBNum_issue2_in(lane_e[2][5:0]),
    .flush_in(flush_in), .stall_out(stall_out),
    .cmp0_valid_out(cmp0_valid_out), .cmp0_PC_out(cmp0_PC_out), .cmp0_result_out(cmp0_result_out),
    .cmp0_destReg_out(cmp0_destReg_out), .cmp0_ROBNum_out(cmp0_ROBNum_out),
    .cmp1_valid_out(cmp1_valid_out), .cmp1_PC_out(cmp1_PC_out), .cmp1_result_out(cmp1_result_out),
    .cmp1_destReg_out(cmp1_destReg_out), .cmp1_ROBNum_out(cmp1_ROBNum_out)
  );

  wire [75:0] out0 = {cmp0_PC_out, cmp0_result_out, cmp0_destReg_out, cmp0_ROBNum_out};
  wire [75:0] out1 = {cmp1_PC_out, cmp1_result_out, cmp1_destReg_out, cmp1_ROBNum_out};

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending completions plus the two output slots.
  logic [75:0] mq[$];
  logic        mv[2];
  logic [75:0] md[2];

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 2; k++) begin mv[k] = 1'b0; md[k] = '0; end
  endtask

  task automatic model_step();
    logic [75:0] acc[$];
    if (flush_in) begin
      mq.delete();
      mv[0] = 1'b0; mv[1] = 1'b0;
    end else begin
      if (mq.size() <= DEPTH - 3)
        for (int i = 0; i < 3; i++) if (lane_v[i]) acc.push_back(ent(lane_rob[i]));
      for (int k = 0; k < 2; k++) begin
        mv[k] = 1'b0;
        if (BYP && mq.size() == 0) begin
          if (acc.size() > 0) begin mv[k] = 1'b1; md[k] = acc.pop_front(); end
        end else if (mq.size() > 0) begin
          mv[k] = 1'b1; md[k] = mq.pop_front();
        end
      end
      foreach (acc[i]) mq.push_back(acc[i]);
    end
  endtask

  logic       collect = 1'b0;
  logic [5:0] seen[$];

  task automatic cycle(input logic [2:0] v, input logic [5:0] r0, input logic [5:0] r1,
                       input logic [5:0] r2, input logic fl);
    lane_v = v; lane_rob[0] = r0; lane_rob[1] = r1; lane_rob[2] = r2; flush_in = fl;
    model_step();
    @(posedge clk); #1;
    chk("model_stall", {75'd0, stall_out}, {75'd0, mq.size() > DEPTH - 3});
    chk("model_v0", {75'd0, cmp0_valid_out}, {75'd0, mv[0]});
    chk("model_v1", {75'd0, cmp1_valid_out}, {75'd0, mv[1]});
    chk("model_d0", out0, md[0]);
    chk("model_d1", out1, md[1]);
    if (collect) begin
      if (cmp0_valid_out) seen.push_back(cmp0_ROBNum_out);
      if (cmp1_valid_out) seen.push_back(cmp1_ROBNum_out);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic check_order(input string name, input int unsigned exp_n);
    logic ok;
    ok = (seen.size() == exp_n);
    for (int i = 1; i < seen.size(); i++) if (seen[i] <= seen[i-1]) ok = 1'b0;
    chk(name, {75'd0, ok}, 76'd1);
  endtask

  typedef struct {
    logic [2:0] v;
    logic [5:0] r0, r1, r2;
    logic       fl;
    logic       ev0;
    logic [5:0] er0;
    logic       ev1;
    logic [5:0] er1;
    logic       es;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic       saw_stall;
    int         groups;
    logic [5:0] rob;

    for (int i = 0; i < 3; i++) lane_rob[i] = '0;
`ifdef COMPLETE_ARBITER_BYPASS_EN
    tbl[0] = '{3'b111, 6'd1, 6'd2, 6'd3, 1'b0, 1'b1, 6'd1, 1'b1, 6'd2, 1'b0};
    tbl[1] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0, 6'd2, 1'b0};
    tbl[2] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd3, 1'b0, 6'd2, 1'b0};
    tbl[3] = '{3'b101, 6'd5, 6'd6, 6'd7, 1'b0, 1'b1, 6'd5, 1'b1, 6'd7, 1'b0};
    tbl[4] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd5, 1'b0, 6'd7, 1'b0};
    tbl[5] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd5, 1'b0, 6'd7, 1'b0};
`else
    tbl[0] = '{3'b111, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0};
    tbl[1] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd1, 1'b1, 6'd2, 1'b0};
    tbl[2] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0, 6'd2, 1'b0};
    tbl[3] = '{3'b101, 6'd5, 6'd6, 6'd7, 1'b0, 1'b0, 6'd3, 1'b0, 6'd2, 1'b0};
    tbl[4] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd5, 1'b1, 6'd7, 1'b0};
    tbl[5] = '{3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd5, 1'b0, 6'd7, 1'b0};
`endif

    model_reset();
    #12;
    chk("rst_v0", {75'd0, cmp0_valid_out}, 76'd0);
    chk("rst_v1", {75'd0, cmp1_valid_out}, 76'd0);
    chk("rst_d0", out0, 76'd0);
    chk("rst_d1", out1, 76'd0);
    chk("rst_stall", {75'd0, stall_out}, 76'd0);
    @(negedge clk); rstn = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].fl);
      chk($sformatf("tbl%0d_v0", i), {75'd0, cmp0_valid_out}, {75'd0, tbl[i].ev0});
      chk($sformatf("tbl%0d_r0", i), {70'd0, cmp0_ROBNum_out}, {70'd0, tbl[i].er0});
      chk($sformatf("tbl%0d_v1", i), {75'd0, cmp1_valid_out}, {75'd0, tbl[i].ev1});
      chk($sformatf("tbl%0d_r1", i), {70'd0, cmp1_ROBNum_out}, {70'd0, tbl[i].er1});
      chk($sformatf("tbl%0d_stall", i), {75'd0, stall_out}, {75'd0, tbl[i].es});
    end

    // Saturating burst: upstream holds its group while stall_out is high.
    seen.delete(); collect = 1'b1; saw_stall = 1'b0; groups = 0; rob = 6'd10;
    for (int c = 0; c < 20 && groups < 6; c++) begin
      if (stall_out) cycle(3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      else begin
        cycle(3'b111, rob, rob + 6'd1, rob + 6'd2, 1'b0);
        rob = rob + 6'd3; groups++;
      end
      saw_stall |= stall_out;
    end
    idle(12);
    collect = 1'b0;
    chk("burst_stall_seen", {75'd0, saw_stall}, 76'd1);
    chk("burst_groups", 76'(groups), 76'd6);
    check_order("burst_order", 18);

    // Pointer wrap: park the write pointer at DEPTH-1 then push a full group.
    rstn = 1'b0; model_reset(); #1; @(negedge clk); rstn = 1'b1;
    seen.delete(); collect = 1'b1;
    cycle(3'b111, 6'd30, 6'd31, 6'd32, 1'b0);
    cycle(3'b111, 6'd33, 6'd34, 6'd35, 1'b0);
    cycle(3'b001, 6'd36, 6'd0, 6'd0, 1'b0);
    idle(6);
    cycle(3'b111, 6'd37, 6'd38, 6'd39, 1'b0);
    idle(4);
    collect = 1'b0;
    check_order("wrap_order", 10);

    // Flush with entries buffered and lanes valid on the same edge.
    cycle(3'b111, 6'd40, 6'd41, 6'd42, 1'b0);
    cycle(3'b111, 6'd43, 6'd44, 6'd45, 1'b0);
    cycle(3'b111, 6'd50, 6'd51, 6'd52, 1'b1);
    chk("flush_v0", {75'd0, cmp0_valid_out}, 76'd0);
    chk("flush_v1", {75'd0, cmp1_valid_out}, 76'd0);
    chk("flush_stall", {75'd0, stall_out}, 76'd0);
    idle(1);
    chk("flush_drop_v0", {75'd0, cmp0_valid_out}, 76'd0);
    chk("flush_drop_v1", {75'd0, cmp1_valid_out}, 76'd0);

    // Asynchronous reset in the middle of a burst.
    cycle(3'b111, 6'd60, 6'd61, 6'd62, 1'b0);
    cycle(3'b111, 6'd63, 6'd0, 6'd1, 1'b0);
    lane_v = 3'b111;
    rstn = 1'b0; model_reset(); #1;
    chk("midrst_v0", {75'd0, cmp0_valid_out}, 76'd0);
    chk("midrst_v1", {75'd0, cmp1_valid_out}, 76'd0);
    chk("midrst_d0", out0, 76'd0);
    chk("midrst_d1", out1, 76'd0);
    chk("midrst_stall", {75'd0, stall_out}, 76'd0);
    @(negedge clk); rstn = 1'b1;
    cycle(3'b001, 6'd9, 6'd0, 6'd0, 1'b0);
`ifdef COMPLETE_ARBITER_BYPASS_EN
    chk("rob9_v0", {75'd0, cmp0_valid_out}, 76'd1);
    chk("rob9_r0", {70'd0, cmp0_ROBNum_out}, 76'd9);
`else
    chk("rob9_early", {75'd0, cmp0_valid_out}, 76'd0);
    idle(1);
    chk("rob9_v0", {75'd0, cmp0_valid_out}, 76'd1);
    chk("rob9_r0", {70'd0, cmp0_ROBNum_out}, 76'd9);
`endif
    idle(2);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(3'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
            ($urandom_range(0, 29) == 0));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/complete_arbiter.md
COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, completion FIFO entries (power of two, >= 4).
REQ-002 SHALL have parameter NUM_OUT, default 2, completion ports per cycle (fixed 2 in this revision).
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports valid_issueN_in  input  1  lane N (N=0..2) carries a result this cycle.
REQ-006 SHALL have ports PC_issueN_in  input  32, aluOutput_issueN_in  input  32, destReg_issueN_in  input  6, ROBNum_issueN_in  input  6, all per lane N=0..2, from the EX/MEM register.
REQ-007 SHALL have port flush_in  input  1  discard all buffered and pending completions.
REQ-008 SHALL have port stall_out  output  1  upstream holds lanes; free entries < 3.
REQ-009 SHALL have ports cmpK_valid_out  output  1, cmpK_PC_out  output  32, cmpK_result_out  output  32, cmpK_destReg_out  output  6, cmpK_ROBNum_out  output  6, for K=0..1, registered ROB/CDB completion broadcast.

Function
REQ-010 SHALL, each edge with stall_out=0 and flush_in=0, enqueue all valid lanes, compacted in lane order 0,1,2 (lowest lane = oldest).
REQ-011 SHALL ignore lane inputs on any edge where stall_out=1.
REQ-012 SHALL drive stall_out combinationally from registered count: stall_out = (count > DEPTH-3).
REQ-013 SHALL dequeue min(count,2) oldest entries per edge into cmp0 (oldest) then cmp1; unused port valid=0.
REQ-014 SHALL keep count = old count + enqueued - dequeued, width clog2(DEPTH)+1, never above DEPTH or below 0.
REQ-015 SHALL use wrapping read/write pointers modulo DEPTH; wrap mid-burst preserves order.
REQ-016 SHALL, without bypass, give latency of exactly 2 edges from lane capture to cmp output valid.
REQ-017 SHALL, on simultaneous enqueue and dequeue, dequeue from pre-edge contents only.
REQ-018 SHALL, when flush_in=1 at an edge, clear pointers, count, and both cmpK_valid_out; flush overrides enqueue and dequeue.
REQ-019 SHALL hold cmpK data fields at last value when the corresponding valid is 0.
REQ-020 SHALL never reorder entries; ROBNum sequence out equals compacted sequence in.

Reset
REQ-021 SHALL, on rstn low, asynchronously clear count, read/write pointers, cmpK_valid_out, and all cmpK data outputs to 0.
REQ-022 SHALL drop in-flight entries on reset mid-operation; stall_out=0 while rstn low.
REQ-023 SHALL resume accepting lanes on the first rising edge after rstn deasserts.

Configuration
REQ-024 SHALL support macro COMPLETE_ARBITER_BYPASS_EN.
REQ-025 SHALL, with COMPLETE_ARBITER_BYPASS_EN defined and count=0, load up to two oldest valid lanes directly into cmp0/cmp1 at the capture edge (latency 1 edge), enqueueing only the remainder.
REQ-026 SHALL, without COMPLETE_ARBITER_BYPASS_EN, route every result through the FIFO (REQ-016).

Structure
REQ-027 SHALL place completion entry typedef (PC, result, destReg, ROBNum), DEPTH/NUM_OUT defaults, and 6-bit tag width constants in the shared core package.
REQ-028 SHALL implement storage as one sub-module cmp_fifo (3-write, 2-read, circular); compaction and output registers stay in complete_arbiter.

Verification
REQ-029 SHALL cover: all 3 lanes valid, ROBNum 1,2,3, FIFO empty -> edge+2: cmp0=1, cmp1=2; edge+3: cmp0=3, cmp1 valid=0.
REQ-030 SHALL cover: lanes 0 and 2 valid only (ROB 5, 7) -> compacted, cmp0=5, cmp1=7 same cycle.
REQ-031 SHALL cover: 3 lanes valid every cycle for 6 cycles, DEPTH=8 -> stall_out rises once count > 5, no entry lost or duplicated, output order strictly increasing ROBNum.
REQ-032 SHALL cover: pointers at DEPTH-1 with 3 enqueues -> wrap to 0..1, output order preserved.
REQ-033 SHALL cover: flush_in with count=4 and simultaneous valid lanes -> next edge count=0, both valid=0, lanes dropped.
REQ-034 SHALL cover: rstn low mid-burst -> outputs 0 immediately; with COMPLETE_ARBITER_BYPASS_EN, lane ROB 9 into empty FIFO -> cmp0=9 after 1 edge.
